// File: rtl/conv_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_mem_arbiter
// Purpose  : Shares the single-port data memory between the convolution
//            engine requesters (0 = filter loader, 1 = IFM buffer loader,
//            2 = OFM writer). Whole bursts are granted round-robin; the
//            granted requester's address, write enable and write data are
//            steered combinationally to the memory port. Read data arrives
//            one cycle after a read beat and goes back to the requester that
//            issued it.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            req/we_req/last_req - per-requester request, write, last beat
//            addr_req/wdata_req  - flattened per-requester address / data
//            gnt                 - registered one-hot burst grant
//            mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
//            rdata/rvalid        - shared read data, one-hot read valid
//            busy                - a burst is in progress
// Revision : 1.0 - initial release
// ============================================================================
module conv_mem_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int IDLE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we_req,
  input  logic [NREQ-1:0]          last_req,
  input  logic [NREQ*ADDR_W-1:0]   addr_req,
  input  logic [NREQ*DATA_W-1:0]   wdata_req,
  output logic [NREQ-1:0]          gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          rvalid,
  output logic                     busy
);

  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STALL_W = $clog2(IDLE_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [STALL_W-1:0]  stall_q, stall_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand;
  logic                beat;
  logic [STALL_W-1:0]  stall_inc;

  // Round-robin search: first asserted request after the last winner.
  // rr_ptr_q also doubles as the granted index while a burst is active.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Memory port steering; all fields forced to zero when no beat happens.
  always_comb begin
    beat      = (state_q == ST_BURST) && req[rr_ptr_q];
    mem_en    = beat;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (beat) begin
      mem_we    = we_req[rr_ptr_q];
      mem_addr  = addr_req[int'(rr_ptr_q)*ADDR_W +: ADDR_W];
      mem_wdata = wdata_req[int'(rr_ptr_q)*DATA_W +: DATA_W];
    end
  end

  // Next-state logic for the burst FSM and read-return pipeline.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    stall_d   = stall_q;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    stall_inc = stall_q + STALL_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d         = ST_BURST;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          rr_ptr_d        = win_idx;
          stall_d         = '0;
        end
      end
      ST_BURST: begin
        if (beat) begin
          stall_d = '0;
          if (last_req[rr_ptr_q]) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (stall_inc == STALL_W'(IDLE_MAX)) begin
          // Requester went quiet too long: abandon the burst.
          state_d = ST_IDLE;
          gnt_d   = '0;
          stall_d = '0;
        end else begin
          stall_d = stall_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (beat && !we_req[rr_ptr_q]) begin
      rvalid_d[rr_ptr_q] = 1'b1;
    end

    // Remember the returned word so rdata holds between pulses.
    if (|rvalid_q) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= IDX_W'(NREQ - 1);
      stall_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      stall_q  <= stall_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory read latency is one cycle, so the return pulse passes the
  // memory output straight through in the cycle it is valid.
  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = (|rvalid_q) ? mem_rdata : rdata_q;
  assign busy   = (state_q == ST_BURST);

endmodule
`default_nettype wire
